// File: rtl/prbs31_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prbs31_burst_ctrl
// Purpose  : Seeds a PRBS31 (x^31 + x^28 + 1) generator and streams bursts of
//            bytes over valid/ready, pulsing done at the end of each burst.
//            Optional error injection on dout[0] when PRBS31_ERRINJ_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module prbs31_burst_ctrl #(
    parameter int          LEN_W    = 16,
    parameter logic [30:0] SEED_RST = 31'h7FFFFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [30:0]      seed_in,
    input  logic             seed_load,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             start,
    input  logic             abort,
    output logic [7:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done,
    output logic             err_seed,
    output logic [1:0]       state_o
`ifdef PRBS31_ERRINJ_EN
   ,input  logic             inject_err
`endif
);

    localparam logic [1:0]       C_IDLE = 2'd0;
    localparam logic [1:0]       C_RUN  = 2'd1;
    localparam logic [1:0]       C_DONE = 2'd2;
    localparam logic [LEN_W-1:0] C_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    // Eight unrolled steps; the byte is the last eight feedback bits, which
    // land in t[7:0] with the first-generated bit in t[7].
    function automatic logic [30:0] step8(input logic [30:0] s);
        logic [30:0] t;
        logic        fb;
        t = s;
        for (int i = 0; i < 8; i++) begin
            fb = t[30] ^ t[27];
            t  = {t[29:0], fb};
        end
        return t;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [30:0]      seed_q, seed_d;
    logic [30:0]      lfsr_q, lfsr_d;
    logic [7:0]       dout_q, dout_d;
    logic             valid_q, valid_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             err_q, err_d;
`ifdef PRBS31_ERRINJ_EN
    logic             pend_q, pend_d;
`endif

    logic        seed_wr;
    logic [30:0] seed_eff;
    logic [30:0] first_st;
    logic [30:0] next_st;
    logic        hs;
    logic        last;
    logic        load_first;
    logic        load_next;

    // Write-through so a same-cycle seed_load feeds the burst being started.
    assign seed_wr    = (state_q == C_IDLE) && seed_load && (seed_in != '0);
    assign seed_eff   = seed_wr ? seed_in : seed_q;
    assign first_st   = step8(seed_eff);
    assign next_st    = step8(lfsr_q);
    assign hs         = valid_q && dout_ready;
    assign last       = (count_q == (len_q - C_ONE));
    assign load_first = (state_q == C_IDLE) && start && (burst_len != '0);
    assign load_next  = (state_q == C_RUN) && !abort && hs && !last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= C_IDLE;
            seed_q  <= SEED_RST;
            lfsr_q  <= SEED_RST;
            dout_q  <= '0;
            valid_q <= 1'b0;
            len_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
`ifdef PRBS31_ERRINJ_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            lfsr_q  <= lfsr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            len_q   <= len_d;
            count_q <= count_d;
            err_q   <= err_d;
`ifdef PRBS31_ERRINJ_EN
            pend_q  <= pend_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE: if (start) state_d = (burst_len == '0) ? C_DONE : C_RUN;
            C_RUN: begin
                if (abort)          state_d = C_IDLE;
                else if (hs && last) state_d = C_DONE;
            end
            C_DONE:  state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        seed_d  = seed_q;
        lfsr_d  = lfsr_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        len_d   = len_q;
        count_d = count_q;
        err_d   = err_q;

        if (seed_wr) seed_d = seed_in;
        if ((state_q == C_IDLE) && seed_load && (seed_in == '0)) err_d = 1'b1;

        if (load_first) begin
            lfsr_d  = first_st;
            dout_d  = first_st[7:0];
            valid_d = 1'b1;
            len_d   = burst_len;
            count_d = '0;
        end

        if (state_q == C_RUN) begin
            if (abort) begin
                valid_d = 1'b0;
            end else if (hs && last) begin
                valid_d = 1'b0;
            end else if (load_next) begin
                count_d = count_q + C_ONE;
                lfsr_d  = next_st;
                dout_d  = next_st[7:0];
            end
        end

`ifdef PRBS31_ERRINJ_EN
        // Only the presented byte is corrupted; the LFSR keeps the clean state.
        pend_d = pend_q | inject_err;
        if ((load_first || load_next) && pend_d) begin
            dout_d[0] = ~dout_d[0];
            pend_d    = 1'b0;
        end
`endif
    end

    always_comb begin
        busy       = (state_q == C_RUN) || (state_q == C_DONE);
        done       = (state_q == C_DONE);
        state_o    = state_q;
        dout       = dout_q;
        dout_valid = valid_q;
        err_seed   = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_prbs31_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs31_burst_ctrl
// Purpose  : Self-checking bench for prbs31_burst_ctrl against a bit-sequence
//            reference model (recurrence x[n] = x[n-31] ^ x[n-28]).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs31_burst_ctrl;

    localparam int          LEN_W    = 16;
    localparam logic [30:0] SEED_RST = 31'h7FFFFFFF;

    logic             clk = 1'b0;
    logic             rst;
    logic [30:0]      seed_in;
    logic             seed_load;
    logic [LEN_W-1:0] burst_len;
    logic             start;
    logic             abort;
    logic [7:0]       dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             done;
    logic             err_seed;
    logic [1:0]       state_o;
`ifdef PRBS31_ERRINJ_EN
    logic             inject_err;
`endif

    always #5 clk = ~clk;

    prbs31_burst_ctrl #(.LEN_W(LEN_W), .SEED_RST(SEED_RST)) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_in    (seed_in),
        .seed_load  (seed_load),
        .burst_len  (burst_len),
        .start      (start),
        .abort      (abort),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done),
        .err_seed   (err_seed),
        .state_o    (state_o)
`ifdef PRBS31_ERRINJ_EN
       ,.inject_err (inject_err)
`endif
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [30:0] m_seed;
    logic        m_err;
    logic [7:0]  exp_b [0:127];

    typedef struct {
        logic        ld;
        logic [30:0] seed;
        int          len;
        int          rmode;    // 0: always ready, 1: toggle, 2: random
        int          abort_at; // handshake count at which abort is raised, -1 none
        logic [31:0] exp4;     // hand-derived first four bytes, dout[7] first
        logic        chk4;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: bit stream starts with seed bits oldest-first (s[30]..s[0]).
    function automatic void gen_bytes(input logic [30:0] sd, input int n);
        bit         q[$];
        int         nb;
        logic [7:0] b;
        for (int i = 30; i >= 0; i--) q.push_back(sd[i]);
        nb = (n > 128) ? 128 : n;
        for (int i = 0; i < 8 * nb; i++) q.push_back(q[q.size() - 31] ^ q[q.size() - 28]);
        for (int k = 0; k < nb; k++) begin
            b = '0;
            for (int j = 0; j < 8; j++) b = {b[6:0], q[31 + 8 * k + j]};
            exp_b[k] = b;
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        m_seed = SEED_RST;
        m_err  = 1'b0;
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic run_burst(input vec_t v, input string tag);
        int         hs, budget, cyc;
        logic       fin, seen_done, aborting, stall, tog, rdy;
        logic [7:0] prev_dout, cbyte;
        logic [31:0] e4;

        seed_in    = v.seed;
        seed_load  = v.ld;
        burst_len  = LEN_W'(v.len);
        start      = 1'b1;
        dout_ready = 1'b0;
        if (v.ld && v.seed != 31'd0) m_seed = v.seed;
        if (v.ld && v.seed == 31'd0) m_err = 1'b1;
        gen_bytes(m_seed, v.len);
        @(negedge clk);
        seed_load = 1'b0;
        start     = 1'b0;

        if (v.len == 0) check({tag, "_len0_done"}, 32'(done), 32'd1);
        hs = 0; fin = 1'b0; seen_done = 1'b0; aborting = 1'b0; stall = 1'b0;
        tog = 1'b0; prev_dout = '0; e4 = v.exp4;
        budget = 8 * v.len + 20;
        cyc = 0;
        while (!fin) begin
            if (cyc >= budget) begin
                check({tag, "_timeout"}, 32'(cyc), 32'(budget - 1));
                fin = 1'b1;
            end else if (aborting) begin
                check({tag, "_abort_valid"}, 32'(dout_valid), 32'd0);
                check({tag, "_abort_state"}, 32'(state_o), 32'd0);
                check({tag, "_abort_nodone"}, 32'(done), 32'd0);
                fin = 1'b1;
            end else if (seen_done) begin
                check({tag, "_post_state"}, 32'(state_o), 32'd0);
                check({tag, "_post_done"}, 32'(done), 32'd0);
                check({tag, "_post_busy"}, 32'(busy), 32'd0);
                fin = 1'b1;
            end else begin
                check({tag, "_busy"}, 32'(busy), 32'd1);
                if (done) begin
                    seen_done = 1'b1;
                    check({tag, "_hs_at_done"}, 32'(hs), 32'(v.len));
                    check({tag, "_valid_at_done"}, 32'(dout_valid), 32'd0);
                    if (v.rmode == 2) abort = 1'($urandom % 2);
                end else begin
                    if (stall) check({tag, "_stall_hold"}, 32'(dout), 32'(prev_dout));
                    check({tag, "_valid"}, 32'(dout_valid), 32'd1);
                    case (v.rmode)
                        0:       rdy = 1'b1;
                        1:       begin tog = ~tog; rdy = tog; end
                        default: rdy = 1'($urandom % 2);
                    endcase
                    dout_ready = rdy;
                    if (v.rmode == 2) begin
                        seed_load = 1'($urandom % 2);
                        seed_in   = ($urandom % 2) ? 31'd0 : 31'($urandom);
                        start     = 1'($urandom % 2);
                    end
                    if (v.abort_at >= 0 && hs == v.abort_at) begin
                        abort    = 1'b1;
                        aborting = 1'b1;
                    end
                    if (dout_valid && rdy) begin
                        if (hs < 128) check({tag, "_byte_model"}, 32'(dout), 32'(exp_b[hs]));
                        if (v.chk4 && hs < 4) begin
                            cbyte = e4[31 - 8 * hs -: 8];
                            check({tag, "_byte_const"}, 32'(dout), 32'(cbyte));
                        end
                        hs++;
                    end
                    stall     = dout_valid && !rdy;
                    prev_dout = dout;
                end
            end
            @(negedge clk);
            abort     = 1'b0;
            seed_load = 1'b0;
            start     = 1'b0;
            if (!seen_done && !aborting) ; else dout_ready = 1'b0;
            cyc++;
        end
        dout_ready = 1'b0;
        check({tag, "_err_seed"}, 32'(err_seed), 32'(m_err));
    endtask

    vec_t vecs [7];
    vec_t rv;

    initial begin
        rst = 1'b1; seed_in = '0; seed_load = 1'b0; burst_len = '0;
        start = 1'b0; abort = 1'b0; dout_ready = 1'b0;
`ifdef PRBS31_ERRINJ_EN
        inject_err = 1'b0;
`endif
        m_seed = SEED_RST; m_err = 1'b0;

        vecs[0] = '{1'b0, 31'd0,          4,  0, -1, 32'h0000000E, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 31'd0,          4,  1, -1, 32'h0000000E, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 31'd0,          1,  0, -1, 32'h00000000, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 31'd1,          6,  2, -1, 32'h00000012, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 31'd0,          4,  1, -1, 32'h00000012, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 31'd0,          0,  0, -1, 32'h00000000, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 31'h25A5A5A5,  10,  2, -1, 32'h00000000, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_seed), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_burst(vecs[i], $sformatf("vec%0d", i));
            check($sformatf("vec%0d_err_exp", i), 32'(err_seed), 32'(vecs[i].exp_err));
        end

        // Abort mid-burst, then a fresh burst restarts from the seed.
        do_reset();
        run_burst('{1'b0, 31'd0, 100, 0, 10, 32'h0000000E, 1'b1, 1'b0}, "abort");
        run_burst('{1'b0, 31'd0, 4, 0, -1, 32'h0000000E, 1'b1, 1'b0}, "after_abort");

        // Reset in the middle of a burst.
        burst_len = 16'd20; start = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_state", 32'(state_o), 32'd0);
        check("midrst_valid", 32'(dout_valid), 32'd0);
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        rst = 1'b0; dout_ready = 1'b0;
        m_seed = SEED_RST; m_err = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 25; i++) begin
            rv.ld       = (($urandom % 3) == 0);
            rv.seed     = (($urandom % 4) == 0) ? 31'd0 : 31'($urandom);
            rv.len      = $urandom_range(0, 12);
            rv.rmode    = $urandom_range(0, 2);
            rv.abort_at = (rv.len > 0 && ($urandom % 4) == 0) ? $urandom_range(0, rv.len - 1) : -1;
            rv.exp4     = '0;
            rv.chk4     = 1'b0;
            rv.exp_err  = 1'b0;
            run_burst(rv, $sformatf("rnd%0d", i));
        end

`ifdef PRBS31_ERRINJ_EN
        begin
            logic [7:0] inj_exp [4];
            inj_exp = '{8'h00, 8'h00, 8'h01, 8'h0E};
            do_reset();
            burst_len = 16'd4; start = 1'b1; dout_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int k = 0; k < 4; k++) begin
                check("inj_valid", 32'(dout_valid), 32'd1);
                check("inj_byte", 32'(dout), 32'(inj_exp[k]));
                inject_err = (k == 1);
                @(negedge clk);
                inject_err = 1'b0;
            end
            check("inj_done", 32'(done), 32'd1);
            dout_ready = 1'b0;
            @(negedge clk);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prbs31_burst_ctrl.md
Name: prbs31_burst_ctrl

Overview:
- Controller and sequencer for the PRBS31 pattern datapath (x^31 + x^28 + 1).
- On command, loads a programmed seed and emits a burst of a requested number of PRBS bytes over a valid/ready stream.
- Pulses done at the end of each burst.
- Sits between the pin-level command/config logic and the byte output toward uo_out.

Parameters:
- LEN_W, 16, width of the burst length in bytes.
- SEED_RST, 31'h7FFFFFFF, reset value of the seed register; must be nonzero.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- seed_in  in  31  seed value.
- seed_load  in  1  write seed_in into the seed register.
- burst_len  in  LEN_W  number of bytes in a burst; sampled at start.
- start  in  1  begin a burst.
- abort  in  1  terminate the current burst.
- dout  out  8  PRBS byte, first-generated bit in dout[7].
- dout_valid  out  1  dout holds a valid byte.
- dout_ready  in  1  downstream accepts dout.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse at the end of a burst.
- err_seed  out  1  sticky flag: a zero seed was rejected.
- state_o  out  2  current state: IDLE=0, RUN=1, DONE=2.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; seed register=SEED_RST; LFSR=SEED_RST; byte count=0.
  - dout=0, dout_valid=0, busy=0, done=0, err_seed=0.
- LFSR step:
  - fb = s[30]^s[27]; s <= {s[29:0], fb}; output bit = fb.
  - One byte = 8 steps, computed unrolled in one cycle, MSB first.
- seed_load in IDLE:
  - seed_in != 0: seed register <= seed_in.
  - seed_in == 0: seed register unchanged; err_seed <= 1.
  - Ignored in RUN and DONE.
- err_seed clears only on rst.
- IDLE + start:
  - burst_len == 0: go to DONE; no bytes emitted.
  - Otherwise, at the same edge: LFSR <= seed advanced 8 steps; dout <= first byte; dout_valid <= 1; len register <= burst_len; count <= 0; go to RUN.
  - Latency from start to dout_valid is 1 cycle.
- start and seed_load in the same cycle in IDLE: seed_load takes effect first and the burst uses the new seed (write-through).
- RUN:
  - dout and dout_valid stay stable while dout_valid=1 and dout_ready=0.
  - On handshake (valid & ready) with count == len-1: dout_valid <= 0, go to DONE.
  - On handshake otherwise: count++, dout <= next byte, LFSR advances 8 steps; no bubble, one byte per cycle max.
- DONE: done=1 for exactly one cycle, then IDLE.
- abort in RUN:
  - Next state is IDLE; dout_valid <= 0; no done pulse.
  - abort wins over a simultaneous handshake: that byte counts as accepted downstream, but no further bytes are emitted.
- abort in IDLE or DONE: no effect.
- start in RUN or DONE: ignored.
- Every burst restarts from the seed register, so identical seeds give identical bursts.
- rst mid-burst: immediate return to reset values; no done pulse.
- Count arithmetic is LEN_W bits. burst_len = 2^LEN_W-1 is the maximum burst; no wrap occurs within a burst.

Optional Feature:
- Macro: PRBS31_ERRINJ_EN.
- Defined:
  - Adds input inject_err (1).
  - A pulse latches a pending flag.
  - The next byte loaded into dout (first byte or post-handshake byte) has dout[0] inverted; the flag then clears.
  - LFSR state is not affected, so later bytes are clean.
  - A pending flag survives until used; it clears on rst, but not on abort.
- Undefined: no port, no logic; output is always the pure sequence.

Test Plan:
- Reset, then start with burst_len=4, dout_ready=1, default seed -> dout_valid high one cycle after start; bytes 0x00,0x00,0x00,0x0E; done pulses once; state_o returns to 0.
- Same burst with dout_ready toggled 1/0 every cycle -> identical 4 bytes; dout held stable during stalls; exactly 4 handshakes before done.
- seed_load with seed_in=0, then start, burst_len=1 -> err_seed=1; output byte 0x00 (default seed retained).
- burst_len=0 + start -> done pulse 1 cycle later, dout_valid never asserted.
- burst_len=100, abort after 10 handshakes -> dout_valid drops next cycle; no done; state IDLE. A new start reproduces the first bytes 0x00,0x00,0x00,0x0E.
- (PRBS31_ERRINJ_EN) inject_err during byte 2 of a 4-byte default burst -> bytes 0x00,0x00,0x01,0x0E.
